prio_encoder_rr: RTL and testbench
==================================

# prio_encoder_rr

Parametrised N-input priority encoder with a registered, handshaked output and a selectable fixed-priority or round-robin arbitration mode. It generalises the team's 4-to-2 combinational encoder. It handles any N ≥ 2, reports multiple-hot and no-hot conditions, and holds its result under downstream backpressure. It sits between a one-hot or multi-hot request vector, such as interrupt or channel-request lines, and a consumer that wants an index plus valid/ready flow control.

## Interface
Parameters:
- N, default 8: number of request inputs; N ≥ 2, need not be a power of two.
- W, derived as $clog2(N), local and not overridable: width of the encoded index.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when low, no new encode is captured.
- mode  input  1  0 = fixed priority (highest set index wins); 1 = round-robin.
- d_in  input  N  request vector.
- ready_in  input  1  downstream accepts the current output.
- y_out  output  W  encoded index of the winning request.
- valid_out  output  1  y_out/multi_out hold a result not yet accepted.
- multi_out  output  1  more than one bit of d_in was set at capture.

## Operation
- Reset, asynchronous:
  - y_out=0, valid_out=0, multi_out=0.
  - Internal round-robin pointer ptr=0.
- Capture condition, cap = en && (!valid_out || ready_in). Output register updates only when cap is high.
- Capture with d_in ≠ 0:
  - mode=0: y_out is the highest set index.
  - mode=1: y_out is the first set index found searching upward from ptr, wrapping N-1 → 0. The search includes ptr itself.
  - valid_out=1.
  - multi_out=1 if popcount(d_in) ≥ 2, else 0.
- Capture with d_in = 0:
  - valid_out=0, multi_out=0.
  - y_out holds its previous value.
  - ptr unchanged.
- en=0 while valid_out && ready_in: valid_out clears at the edge. y_out and multi_out hold.
- valid_out && !ready_in: y_out, valid_out and multi_out hold regardless of d_in, en or mode.
- Pointer:
  - Updates only on a mode=1 capture with d_in ≠ 0: ptr ← (y_new + 1) mod N.
  - Wrap uses mod N, not 2^W. For N not a power of two, ptr never exceeds N-1.
  - Fixed-mode captures leave ptr untouched.
- Mode changes take effect at the next capture. ptr is preserved across mode switches.
- d_in bits are sampled only at a capture edge. Glitches between edges have no effect.

## Timing
- Latency: 1 cycle. Inputs sampled at edge k appear on y_out/valid_out/multi_out after edge k.
- Throughput: 1 result per cycle while ready_in=1 and en=1.
- Accept and capture at the same edge: the old result is consumed and the new result loads. No bubble.
- Reset mid-operation clears outputs immediately, without waiting for clk. The first capture after rst deasserts uses ptr=0.
- No combinational path from d_in, en or mode to the outputs. ready_in → outputs is registered only.

## Test plan
- Async reset: drive valid_out=1, y_out=5, then pulse rst between clock edges → y_out=0, valid_out=0, multi_out=0 before the next edge. The next rr capture of 8'hFF yields y_out=0.
- Fixed priority, N=8: mode=0, en=1, ready_in=1, d_in=8'b0010_1100 → after one edge y_out=5, valid_out=1, multi_out=1. Then d_in=8'b0000_0100 → y_out=2, multi_out=0.
- Round-robin sweep, N=8: mode=1, d_in=8'hFF held, ready_in=1 → y_out sequence 0,1,2,…,7,0 on consecutive cycles, with valid_out=1 throughout.
- Backpressure: capture y_out=3, then ready_in=0 for 4 cycles while d_in changes → y_out=3 and valid_out=1 hold. Raise ready_in=1 → the next edge loads the current d_in result.
- Empty input: d_in=0, en=1, ready_in=1 after a valid result → valid_out=0 next edge, y_out holds, ptr unchanged. The subsequent rr result matches the pre-empty pointer.
- Non-power-of-two wrap, N=5: mode=1, d_in=5'b10001 held → y_out alternates 0,4,0,4. ptr never takes values 5–7.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// N-input priority encoder with a registered valid/ready output stage and
// selectable fixed-priority (highest index wins) or round-robin arbitration.
module prio_encoder_rr #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         d_in,
    input  logic                 ready_in,
    output logic [$clog2(N)-1:0] y_out,
    output logic                 valid_out,
    output logic                 multi_out
);

    localparam int W = $clog2(N);

    logic [W-1:0]   ptr;
    logic           cap;
    logic           any_hot;
    logic           multi_hot;
    logic [W-1:0]   fix_idx;
    logic [2*N-1:0] d_dbl;
    logic [2*N-1:0] d_rot;
    logic [W-1:0]   rot_idx;
    logic [W:0]     rr_sum;
    logic [W-1:0]   rr_idx;
    logic [W-1:0]   win_idx;
    logic [W-1:0]   ptr_next;

    assign cap = en && (!valid_out || ready_in);

    always_comb begin
        any_hot   = 1'b0;
        multi_hot = 1'b0;
        fix_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (d_in[i]) begin
                if (any_hot) multi_hot = 1'b1;
                any_hot = 1'b1;
                fix_idx = W'(i);
            end
        end
    end

    // Rotate the request vector so ptr lands at bit 0; the lowest set bit of
    // the rotated copy is the round-robin winner's offset from ptr.
    assign d_dbl = {d_in, d_in};
    assign d_rot = d_dbl >> ptr;

    always_comb begin
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (d_rot[i]) rot_idx = W'(i);
        end
    end

    // ptr + offset is at most 2N-2, so one conditional subtract gives mod N.
    always_comb begin
        rr_sum = {1'b0, ptr} + {1'b0, rot_idx};
        if (rr_sum >= (W+1)'(N)) begin
            rr_sum = rr_sum - (W+1)'(N);
        end
        rr_idx = rr_sum[W-1:0];
    end

    assign win_idx  = mode ? rr_idx : fix_idx;
    assign ptr_next = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out     <= '0;
            valid_out <= 1'b0;
            multi_out <= 1'b0;
            ptr       <= '0;
        end else if (cap) begin
            if (any_hot) begin
                y_out     <= win_idx;
                valid_out <= 1'b1;
                multi_out <= multi_hot;
                if (mode) ptr <= ptr_next;
            end else begin
                valid_out <= 1'b0;
                multi_out <= 1'b0;
            end
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed + random bench for prio_encoder_rr (N=8 with a scoreboard model,
// N=5 for the non-power-of-two pointer wrap).
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, mode = 1'b0, ready_in = 1'b0;
    logic [7:0] d_in = '0;
    logic [2:0] y_out;
    logic       valid_out, multi_out;

    logic       en5 = 1'b0, mode5 = 1'b0, ready5 = 1'b0;
    logic [4:0] d5 = '0;
    logic [2:0] y5;
    logic       valid5, multi5;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] y;
        logic       v;
        logic       m;
    } exp_t;
    exp_t sb[$];

    logic [2:0] m_y = '0;
    logic       m_valid = 1'b0, m_multi = 1'b0;
    int         m_ptr = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in),
        .ready_in(ready_in), .y_out(y_out), .valid_out(valid_out),
        .multi_out(multi_out)
    );

    prio_encoder_rr #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .en(en5), .mode(mode5), .d_in(d5),
        .ready_in(ready5), .y_out(y5), .valid_out(valid5),
        .multi_out(multi5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y = '0; m_valid = 1'b0; m_multi = 1'b0; m_ptr = 0;
        sb.delete();
    endtask

    // Reference behaviour: linear search from ptr for round robin,
    // highest set bit for fixed priority.
    task automatic model_step(input logic e, input logic md, input logic [7:0] d, input logic rdy);
        int win;
        win = 0;
        if (e && (!m_valid || rdy)) begin
            if (d != 0) begin
                if (md) begin
                    for (int k = 7; k >= 0; k--)
                        if (d[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
                    m_ptr = (win + 1) % 8;
                end else begin
                    for (int i = 0; i < 8; i++) if (d[i]) win = i;
                end
                m_y = 3'(win);
                m_valid = 1'b1;
                m_multi = ($countones(d) >= 2);
            end else begin
                m_valid = 1'b0;
                m_multi = 1'b0;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic e, input logic md, input logic [7:0] d, input logic rdy);
        exp_t x;
        @(negedge clk);
        en = e; mode = md; d_in = d; ready_in = rdy;
        model_step(e, md, d, rdy);
        sb.push_back('{y: m_y, v: m_valid, m: m_multi});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("sb_y", 32'(y_out), 32'(x.y));
        check("sb_valid", 32'(valid_out), 32'(x.v));
        check("sb_multi", 32'(multi_out), 32'(x.m));
    endtask

    initial begin
        #3;
        check("rst_y", 32'(y_out), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_multi", 32'(multi_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority
        step(1, 0, 8'b0010_1100, 1);
        check("fix_y5", 32'(y_out), 5);
        check("fix_multi1", 32'(multi_out), 1);
        step(1, 0, 8'b0000_0100, 1);
        check("fix_y2", 32'(y_out), 2);
        check("fix_multi0", 32'(multi_out), 0);

        // Async reset between edges
        step(1, 0, 8'b0010_0000, 1);
        check("pre_rst_y", 32'(y_out), 5);
        #2 rst = 1'b1;
        #1;
        check("arst_y", 32'(y_out), 0);
        check("arst_valid", 32'(valid_out), 0);
        check("arst_multi", 32'(multi_out), 0);
        #1 rst = 1'b0;
        model_reset();

        // Round-robin sweep
        step(1, 1, 8'hFF, 1);
        check("rr_after_rst", 32'(y_out), 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 8'hFF, 1);
            check("rr_sweep", 32'(y_out), 32'(i % 8));
            check("rr_valid", 32'(valid_out), 1);
        end

        // Backpressure: capture 3, then hold for 4 cycles
        step(1, 1, 8'b0000_1000, 1);
        check("bp_cap", 32'(y_out), 3);
        step(1, 1, 8'b1000_0000, 0);
        step(1, 0, 8'b0000_0001, 0);
        step(0, 1, 8'b0101_0101, 0);
        step(1, 1, 8'b0000_0000, 0);
        check("bp_hold_y", 32'(y_out), 3);
        check("bp_hold_valid", 32'(valid_out), 1);
        step(1, 1, 8'b0100_0000, 1);
        check("bp_release", 32'(y_out), 6);

        // Empty input keeps y and ptr
        step(1, 1, 8'h00, 1);
        check("empty_valid", 32'(valid_out), 0);
        check("empty_y", 32'(y_out), 6);
        step(1, 1, 8'hFF, 1);
        check("empty_ptr_kept", 32'(y_out), 7);

        // en low while accepted: valid clears, data holds
        step(0, 1, 8'hFF, 1);
        check("en0_valid", 32'(valid_out), 0);
        check("en0_y", 32'(y_out), 7);

        // Mode switch keeps ptr
        step(1, 0, 8'b0000_0011, 1);
        check("sw_fixed", 32'(y_out), 1);
        step(1, 1, 8'b0000_0011, 1);
        check("sw_rr", 32'(y_out), 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), rd,
                 1'($urandom_range(0, 2) != 0));
        end

        // N=5 wrap
        @(negedge clk);
        en5 = 1'b1; mode5 = 1'b1; ready5 = 1'b1; d5 = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("n5_wrap", 32'(y5), (i % 2 == 0) ? 0 : 4);
            check("n5_valid", 32'(valid5), 1);
        end
        @(negedge clk);
        en5 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
